shift_pipe: RTL and testbench

- Parametrised, pipelined logarithmic shifter/rotator for the execute path. It generalises the fixed 32-bit SLL/SRL/SRA units.
- Adds configurable width, rotate modes, carry-out and zero flags, per-level pipelining, a valid/ready handshake with back-pressure, a passthrough tag and a synchronous flush.
- Sits between operand issue and ALU writeback mux.

---
 rtl/shift_pipe_if.sv | 36 +++
 rtl/shift_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_shift_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_pipe_if.sv
// Handshake bundle between operand issue and the shift_pipe execute unit.
// The master side presents operations and consumes results; the slave side
// is the shifter itself.
interface shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
);
    localparam int SHW = $clog2(WIDTH);

    // Operation request channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_op;
    logic [TAGW-1:0]  in_tag;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_zero;
    logic             out_illegal;
    logic [TAGW-1:0]  out_tag;

    modport master (
        output in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_carry, out_zero, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_carry, out_zero, out_illegal, out_tag
    );
endinterface

// File: rtl/shift_pipe.sv
// Parametrised logarithmic shifter/rotator (SLL, SRL, SRA, ROL, ROR).
// Level k shifts by 2^k when shamt[k] is set. With PIPE=1 every level has
// its own register (latency SHW); with PIPE=0 all levels are combinational
// and only the output is registered (latency 1). The whole pipeline advances
// as a unit whenever the output is empty or being consumed.
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int PIPE  = 1,
    parameter int TAGW  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    shift_pipe_if.slave bus
);

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_e;

    // Everything that travels alongside the data through each level.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [2:0]       op;
        logic [SHW-1:0]   shamt;
        logic             carry;
        logic             sign;
        logic             illegal;
        logic [TAGW-1:0]  tag;
    } stage_t;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic             zero;
        logic             illegal;
        logic [TAGW-1:0]  tag;
    } result_t;

    // One level of the log shifter. The carry is overwritten by every level
    // that actually shifts, so after the last active level it holds the bit
    // that left the word at the total shift distance. Illegal ops and levels
    // whose shamt bit is clear pass through untouched.
    function automatic stage_t applyLevel(input stage_t s, input int k);
        stage_t           r;
        logic [SHW-1:0]   shBits;
        logic [WIDTH-1:0] outBits;
        int unsigned      amt;
        r       = s;
        amt     = 32'd1 << k;
        shBits  = s.shamt >> k;
        outBits = '0;
        if (shBits[0] && !s.illegal) begin
            case (s.op)
                OP_SLL: begin
                    r.data  = s.data << amt;
                    outBits = s.data >> (WIDTH - amt);
                end
                OP_SRL: begin
                    r.data  = s.data >> amt;
                    outBits = s.data >> (amt - 1);
                end
                OP_SRA: begin
                    r.data  = (s.data >> amt) | ({WIDTH{s.sign}} & ~({WIDTH{1'b1}} >> amt));
                    outBits = s.data >> (amt - 1);
                end
                OP_ROL: begin
                    r.data  = (s.data << amt) | (s.data >> (WIDTH - amt));
                    outBits = s.data >> (WIDTH - amt);
                end
                OP_ROR: begin
                    r.data  = (s.data >> amt) | (s.data << (WIDTH - amt));
                    outBits = s.data >> (amt - 1);
                end
                default: begin
                    r.data  = s.data;
                    outBits = '0;
                end
            endcase
            r.carry = outBits[0];
        end
        return r;
    endfunction

    logic    adv;
    logic    inFire;
    stage_t  entryStage;
    stage_t  last_d;
    logic    lastValid;
    result_t result_q;
    logic    outValid_q;
    logic    unusedLastBits;

    // The pipeline moves only when the output slot is free or being drained;
    // in_ready deliberately ignores in_valid and flush.
    assign adv    = !outValid_q | bus.out_ready;
    assign inFire = bus.in_valid & adv;

    // Capture the operation at entry; the SRA fill bit is frozen here so the
    // later levels never have to look back at the original operand.
    always_comb begin
        entryStage         = '0;
        entryStage.data    = bus.in_a;
        entryStage.op      = bus.in_op;
        entryStage.shamt   = bus.in_shamt;
        entryStage.carry   = 1'b0;
        entryStage.sign    = bus.in_a[WIDTH-1];
        entryStage.illegal = (bus.in_op > OP_ROR);
        entryStage.tag     = bus.in_tag;
    end

    generate
        if (PIPE != 0) begin : gPipelined
            stage_t         stage_q      [SHW-1];
            stage_t         stage_d      [SHW-1];
            logic [SHW-2:0] stageValid_q;
            logic [SHW-2:0] stageValid_d;

            // Levels 0..SHW-2 feed the intermediate registers; the last
            // level feeds the output register directly.
            always_comb begin
                stage_d         = '{default: '0};
                stageValid_d    = '0;
                stage_d[0]      = applyLevel(entryStage, 0);
                stageValid_d[0] = inFire;
                for (int k = 1; k < SHW - 1; k++) begin
                    stage_d[k]      = applyLevel(stage_q[k-1], k);
                    stageValid_d[k] = stageValid_q[k-1];
                end
                last_d    = applyLevel(stage_q[SHW-2], SHW - 1);
                lastValid = stageValid_q[SHW-2];
            end

            // Intermediate stage registers; flush only has to kill the valids,
            // stale data is harmless.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q      <= '{default: '0};
                    stageValid_q <= '0;
                end else begin
                    if (flush) begin
                        stageValid_q <= '0;
                    end else if (adv) begin
                        stageValid_q <= stageValid_d;
                    end
                    if (adv) begin
                        stage_q <= stage_d;
                    end
                end
            end
        end else begin : gCombinational
            stage_t chain [SHW+1];

            // All levels in one combinational cascade ahead of the output register.
            always_comb begin
                chain    = '{default: '0};
                chain[0] = entryStage;
                for (int k = 0; k < SHW; k++) begin
                    chain[k+1] = applyLevel(chain[k], k);
                end
                last_d    = chain[SHW];
                lastValid = inFire;
            end
        end
    endgenerate

    // Op, shamt and sign have done their job by the time the last level is
    // through; they are intentionally dropped here.
    assign unusedLastBits = ^{last_d.op, last_d.shamt, last_d.sign};

    // Output register: zero flag is computed from the same data it is stored
    // with, so it always matches out_y while out_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            result_q   <= '0;
        end else begin
            if (flush) begin
                outValid_q <= 1'b0;
            end else if (adv) begin
                outValid_q <= lastValid;
            end
            if (adv) begin
                result_q.data    <= last_d.data;
                result_q.carry   <= last_d.carry;
                result_q.zero    <= (last_d.data == '0);
                result_q.illegal <= last_d.illegal;
                result_q.tag     <= last_d.tag;
            end
        end
    end

    assign bus.in_ready    = adv;
    assign bus.out_valid   = outValid_q;
    assign bus.out_y       = result_q.data;
    assign bus.out_carry   = result_q.carry;
    assign bus.out_zero    = result_q.zero;
    assign bus.out_illegal = result_q.illegal;
    assign bus.out_tag     = result_q.tag;

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: a 32-bit pipelined instance (latency 5) driven by
// directed tables, stall/flush/reset sequences and a random stream, plus an
// 8-bit combinational instance (latency 1). Expected results come from a
// plain-arithmetic shift model.
module tb_shift_pipe;
    localparam int L = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic flush8;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    bit randReady   = 1'b0;
    bit checkLat    = 1'b0;

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        z;
        logic        il;
        logic [4:0]  tag;
        int          acc;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] y;
        logic        c;
        logic        il;
    } vec_t;

    exp_t expQ[$];
    vec_t tbl[14];

    shift_pipe_if #(.WIDTH(32), .TAGW(5)) bus ();
    shift_pipe_if #(.WIDTH(8),  .TAGW(5)) bus8 ();

    shift_pipe #(.WIDTH(32), .PIPE(1), .TAGW(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );

    shift_pipe #(.WIDTH(8), .PIPE(0), .TAGW(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(bus8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference shifter: whole-word shifts on a 64-bit container, masked to w bits.
    function automatic void refModel(input int w, input logic [31:0] a, input int sh,
                                     input logic [2:0] op, output logic [31:0] y,
                                     output logic c, output logic il);
        longint unsigned m, av, r, sgn;
        m   = (64'd1 << w) - 64'd1;
        av  = {32'd0, a} & m;
        sgn = (av >> (w - 1)) & 64'd1;
        il  = 1'b0;
        c   = 1'b0;
        case (op)
            3'd0: begin
                r = (av << sh) & m;
                c = (sh != 0) && (((av >> (w - sh)) & 64'd1) != 0);
            end
            3'd1: begin
                r = av >> sh;
                c = (sh != 0) && (((av >> (sh - 1)) & 64'd1) != 0);
            end
            3'd2: begin
                r = (av >> sh) | ((sgn != 0) ? (m & ~(m >> sh)) : 64'd0);
                c = (sh != 0) && (((av >> (sh - 1)) & 64'd1) != 0);
            end
            3'd3: begin
                r = ((av << sh) | (av >> (w - sh))) & m;
                c = (sh != 0) && ((r & 64'd1) != 0);
            end
            3'd4: begin
                r = ((av >> sh) | (av << (w - sh))) & m;
                c = (sh != 0) && (((r >> (w - 1)) & 64'd1) != 0);
            end
            default: begin
                r  = av;
                il = 1'b1;
            end
        endcase
        y = r[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Present one op to the 32-bit DUT and hold it until accepted; called and
    // returns just after a rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [4:0] sh,
                                 input logic [4:0] tag, input logic [31:0] ey,
                                 input logic ec, input logic eil);
        exp_t e;
        bit   done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_shamt = sh;
        bus.in_tag   = tag;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.y   = ey;
                e.c   = ec;
                e.z   = (ey == 32'd0);
                e.il  = eil;
                e.tag = tag;
                e.acc = cyc;
                expQ.push_back(e);
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) checkOutput("accept-timeout", 64'd0, 64'd1);
    endtask

    task automatic sendRandom(input logic [4:0] tag);
        logic [2:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] y;
        logic        c;
        logic        il;
        int          pick;
        op   = 3'($urandom_range(0, 7));
        pick = $urandom_range(0, 7);
        a    = (pick == 0) ? 32'd0 : (pick == 1) ? 32'hFFFF_FFFF : $urandom();
        sh   = 5'($urandom_range(0, 31));
        refModel(32, a, int'(sh), op, y, c, il);
        applyStimulus(op, a, sh, tag, y, c, il);
    endtask

    task automatic waitDrain(input string name);
        for (int t = 0; t < 200 && expQ.size() != 0; t++) @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput(name, 64'(expQ.size()), 64'd0);
    endtask

    // One op through the 8-bit combinational instance: result visible one cycle later.
    task automatic sendOp8(input logic [2:0] op, input logic [7:0] a, input logic [2:0] sh,
                           input logic [4:0] tag, input logic [7:0] ey,
                           input logic ec, input logic eil);
        bus8.in_valid = 1'b1;
        bus8.in_op    = op;
        bus8.in_a     = a;
        bus8.in_shamt = sh;
        bus8.in_tag   = tag;
        @(negedge clk);
        checkOutput("w8-in_ready", 64'(bus8.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("w8-result",
                    64'({bus8.out_valid, bus8.out_y, bus8.out_carry, bus8.out_zero, bus8.out_illegal, bus8.out_tag}),
                    64'({1'b1, ey, ec, (ey == 8'd0), eil, tag}));
        @(posedge clk);
        #1;
    endtask

    // Random consumer back-pressure, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randReady) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard: in-order result checking, stall stability and latency.
    initial begin : monitor
        exp_t        e;
        logic [39:0] snap;
        logic [39:0] cur;
        bit          stalled;
        stalled = 1'b0;
        snap    = '0;
        forever begin
            @(negedge clk);
            cur = {bus.out_y, bus.out_carry, bus.out_zero, bus.out_illegal, bus.out_tag};
            if (rst_n && bus.out_valid) begin
                if (stalled) checkOutput("stall-hold", 64'(cur), 64'(snap));
                if (bus.out_ready) begin
                    stalled = 1'b0;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected-valid", 64'd1, 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("result", 64'(cur), 64'({e.y, e.c, e.z, e.il, e.tag}));
                        if (checkLat) checkOutput("latency", 64'(cyc - e.acc), 64'(L));
                    end
                end else begin
                    checkOutput("stall-in_ready", 64'(bus.in_ready), 64'd0);
                    snap    = cur;
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #5000000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        flush8 = 1'b0;
        bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_shamt = '0;  bus.in_op = '0;  bus.in_tag = '0;
        bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_shamt = '0; bus8.in_op = '0; bus8.in_tag = '0;
        bus8.out_ready = 1'b1;

        tbl[0]  = '{3'b000, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b1, 1'b0};
        tbl[1]  = '{3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[2]  = '{3'b100, 32'h0000_0001, 5'd4,  32'h1000_0000, 1'b0, 1'b0};
        tbl[3]  = '{3'b011, 32'h8000_0000, 5'd1,  32'h0000_0001, 1'b1, 1'b0};
        tbl[4]  = '{3'b001, 32'h0000_000F, 5'd4,  32'h0000_0000, 1'b1, 1'b0};
        tbl[5]  = '{3'b111, 32'h1234_5678, 5'd9,  32'h1234_5678, 1'b0, 1'b1};
        tbl[6]  = '{3'b000, 32'hA5A5_F00F, 5'd0,  32'hA5A5_F00F, 1'b0, 1'b0};
        tbl[7]  = '{3'b001, 32'hA5A5_F00F, 5'd0,  32'hA5A5_F00F, 1'b0, 1'b0};
        tbl[8]  = '{3'b010, 32'hA5A5_F00F, 5'd0,  32'hA5A5_F00F, 1'b0, 1'b0};
        tbl[9]  = '{3'b011, 32'hA5A5_F00F, 5'd0,  32'hA5A5_F00F, 1'b0, 1'b0};
        tbl[10] = '{3'b100, 32'hA5A5_F00F, 5'd0,  32'hA5A5_F00F, 1'b0, 1'b0};
        tbl[11] = '{3'b000, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1, 1'b0};
        tbl[12] = '{3'b010, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b0};
        tbl[13] = '{3'b101, 32'h0000_0000, 5'd3,  32'h0000_0000, 1'b0, 1'b1};

        // Reset state
        #1;
        checkOutput("reset-outputs",
                    64'({bus.out_valid, bus.out_y, bus.out_carry, bus.out_zero, bus.out_illegal, bus.out_tag}), 64'd0);
        checkOutput("reset-zero-flag", 64'(bus.out_zero), 64'd0);
        checkOutput("reset-in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset8-outputs",
                    64'({bus8.out_valid, bus8.out_y, bus8.out_carry, bus8.out_zero, bus8.out_illegal, bus8.out_tag}), 64'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table, back-to-back with fixed latency
        checkLat = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].sh, 5'(i + 1), tbl[i].y, tbl[i].c, tbl[i].il);
        end
        waitDrain("drain-table");
        checkLat = 1'b0;

        // Back-pressure: 8 ops with a 3-cycle consumer stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) sendRandom(5'(i));
            end
            begin
                repeat (7) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        waitDrain("drain-stall");

        // Flush: 4 ops in flight plus one presented during the flush cycle
        for (int i = 0; i < 4; i++) sendRandom(5'(i + 10));
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hDEAD_BEEF;
        bus.in_op    = 3'b000;
        bus.in_shamt = 5'd3;
        bus.in_tag   = 5'd31;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        expQ.delete();
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            checkOutput("flush-quiet", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        checkLat = 1'b1;
        applyStimulus(3'b001, 32'hF000_0000, 5'd28, 5'd9, 32'h0000_000F, 1'b0, 1'b0);
        waitDrain("drain-flush");
        checkLat = 1'b0;

        // Asynchronous reset with ops in flight
        applyStimulus(3'b000, 32'h8000_000F, 5'd1, 5'd21, 32'h0000_001E, 1'b1, 1'b0);
        sendRandom(5'd22);
        sendRandom(5'd23);
        for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
        checkOutput("pre-reset-valid", 64'(bus.out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async-reset-outputs",
                    64'({bus.out_valid, bus.out_y, bus.out_carry, bus.out_zero, bus.out_illegal, bus.out_tag}), 64'd0);
        checkOutput("async-reset-zero-flag", 64'(bus.out_zero), 64'd0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checkOutput("post-reset-quiet", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // 8-bit, PIPE=0 instance: hand vectors then random against the model
        sendOp8(3'b010, 8'h90, 3'd3, 5'd1, 8'hF2, 1'b0, 1'b0);
        sendOp8(3'b011, 8'h81, 3'd7, 5'd2, 8'hC0, 1'b0, 1'b0);
        sendOp8(3'b000, 8'h03, 3'd7, 5'd3, 8'h80, 1'b1, 1'b0);
        sendOp8(3'b110, 8'h5A, 3'd2, 5'd4, 8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            logic [2:0]  op;
            logic [7:0]  a;
            logic [2:0]  sh;
            logic [31:0] y;
            logic        c;
            logic        il;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom());
            sh = 3'($urandom_range(0, 7));
            refModel(8, {24'd0, a}, int'(sh), op, y, c, il);
            sendOp8(op, a, sh, 5'(i), y[7:0], c, il);
        end

        // Random stream with bubbles and random back-pressure
        randReady = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                sendRandom(5'(i));
            end
        end
        randReady = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        waitDrain("drain-random");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
